// File: rtl/csc_para_pkg.sv
`default_nettype none
// csc_para_pkg: shared types, address map and shift-clamp helper for the CSC parameter controller.
package csc_para_pkg;

    localparam int ADDR_W   = 4;
    localparam int SHIFT_W  = 5;
    localparam int COL_OFFS = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_APPLY   = 2'd2
    } para_state_t;

    // The shift word sits directly after the last channel's offset.
    function automatic logic [ADDR_W-1:0] addr_shift(input int num_ch);
        return ADDR_W'(num_ch * 4);
    endfunction

    function automatic logic [SHIFT_W-1:0] reset_shift(input int shift_min);
        return SHIFT_W'(shift_min);
    endfunction

    function automatic logic [SHIFT_W-1:0] clamp_shift(
        input logic [SHIFT_W-1:0] raw,
        input int                 lo,
        input int                 hi
    );
        if (raw < SHIFT_W'(lo))
            return SHIFT_W'(lo);
        else if (raw > SHIFT_W'(hi))
            return SHIFT_W'(hi);
        else
            return raw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/csc_shift_decode.sv
`default_nettype none
// csc_shift_decode: combinational raw shift -> clamped shift, half-LSB rounding constant, offset enable.
module csc_shift_decode
    import csc_para_pkg::*;
#(
    parameter int SHIFT_MIN     = 8,
    parameter int SHIFT_MAX     = 17,
    parameter int OFF_SHIFT_MAX = 14,
    parameter int ROUND_W       = 18
) (
    input  logic [SHIFT_W-1:0] raw_shift,
    output logic [SHIFT_W-1:0] shift_eff,
    output logic [ROUND_W-1:0] round_val,
    output logic               offset_en,
    output logic               clamp_flag
);

    always_comb begin
        shift_eff  = clamp_shift(raw_shift, SHIFT_MIN, SHIFT_MAX);
        // SHIFT_MIN >= 1 so the subtraction never wraps.
        round_val  = ROUND_W'(1) << (shift_eff - SHIFT_W'(1));
        offset_en  = (shift_eff <= SHIFT_W'(OFF_SHIFT_MAX));
        clamp_flag = (raw_shift != shift_eff);
    end

endmodule
`default_nettype wire

// File: rtl/csc_para_ctrl.sv
`default_nettype none
// csc_para_ctrl: double-buffered CSC parameter bank; shadow writes over ready/valid,
// committed updates land atomically in the active bank at the next frame boundary.
module csc_para_ctrl
    import csc_para_pkg::*;
#(
    parameter int PARA_DW       = 12,
    parameter int NUM_CH        = 3,
    parameter int SHIFT_MIN     = 8,
    parameter int SHIFT_MAX     = 17,
    parameter int OFF_SHIFT_MAX = 14,
    parameter int ROUND_W       = 18
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        cfg_vld,
    output logic                        cfg_rdy,
    input  logic [ADDR_W-1:0]           cfg_addr,
    input  logic [PARA_DW+7:0]          cfg_data,
    input  logic                        cfg_commit,
    input  logic                        frame_start,
    output logic [NUM_CH*3*PARA_DW-1:0] coef_flat,
    output logic [NUM_CH*(PARA_DW+8)-1:0] offs_flat,
    output logic [SHIFT_W-1:0]          shift_eff,
    output logic [ROUND_W-1:0]          round_val,
    output logic                        offset_en,
    output logic                        clamp_flag,
    output logic                        para_upd,
    output logic                        cfg_err,
    output logic                        pending
);

    localparam int OFF_W = PARA_DW + 8;
    localparam logic [ADDR_W-1:0]  SHIFT_ADDR   = addr_shift(NUM_CH);
    localparam logic [SHIFT_W-1:0] RST_SHIFT    = reset_shift(SHIFT_MIN);
    localparam logic [ROUND_W-1:0] RST_ROUND    = ROUND_W'(1) << (SHIFT_MIN - 1);
    localparam logic               RST_OFF_EN   = (SHIFT_MIN <= OFF_SHIFT_MAX);

    para_state_t state;
    para_state_t state_nxt;
    logic        apply;
    logic        wr_en;
    logic        addr_legal;

    logic [NUM_CH*3*PARA_DW-1:0] sh_coef;
    logic [NUM_CH*OFF_W-1:0]     sh_offs;
    logic [SHIFT_W-1:0]          sh_shift;

    logic [SHIFT_W-1:0]          dec_shift;
    logic [ROUND_W-1:0]          dec_round;
    logic                        dec_off_en;
    logic                        dec_clamp;

    always_ff @(posedge clk_in) begin
        if (rst_in)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (cfg_commit)  state_nxt = ST_PENDING;
            ST_PENDING: if (frame_start) state_nxt = ST_APPLY;
            ST_APPLY:                    state_nxt = ST_IDLE;
            default:                     state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cfg_rdy = (state == ST_IDLE) && !rst_in;
        pending = (state == ST_PENDING);
        apply   = (state == ST_APPLY);
    end

    assign wr_en      = cfg_vld && cfg_rdy;
    assign addr_legal = (cfg_addr <= SHIFT_ADDR);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sh_coef  <= '0;
            sh_offs  <= '0;
            sh_shift <= RST_SHIFT;
            cfg_err  <= 1'b0;
        end else begin
            cfg_err <= wr_en && !addr_legal;
            if (wr_en) begin
                if (cfg_addr == SHIFT_ADDR)
                    sh_shift <= cfg_data[SHIFT_W-1:0];
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    for (int col = 0; col < COL_OFFS; col++) begin
                        if (cfg_addr == ADDR_W'(ch * 4 + col))
                            sh_coef[(ch*COL_OFFS+col)*PARA_DW +: PARA_DW] <= cfg_data[PARA_DW-1:0];
                    end
                    if (cfg_addr == ADDR_W'(ch * 4 + COL_OFFS))
                        sh_offs[ch*OFF_W +: OFF_W] <= cfg_data;
                end
            end
        end
    end

    csc_shift_decode #(
        .SHIFT_MIN     (SHIFT_MIN),
        .SHIFT_MAX     (SHIFT_MAX),
        .OFF_SHIFT_MAX (OFF_SHIFT_MAX),
        .ROUND_W       (ROUND_W)
    ) u_shift_decode (
        .raw_shift  (sh_shift),
        .shift_eff  (dec_shift),
        .round_val  (dec_round),
        .offset_en  (dec_off_en),
        .clamp_flag (dec_clamp)
    );

    // Whole bank moves in one edge, so the MAC array never sees a mixed set.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            coef_flat  <= '0;
            offs_flat  <= '0;
            shift_eff  <= RST_SHIFT;
            round_val  <= RST_ROUND;
            offset_en  <= RST_OFF_EN;
            clamp_flag <= 1'b0;
            para_upd   <= 1'b0;
        end else begin
            para_upd <= apply;
            if (apply) begin
                coef_flat  <= sh_coef;
                offs_flat  <= sh_offs;
                shift_eff  <= dec_shift;
                round_val  <= dec_round;
                offset_en  <= dec_off_en;
                clamp_flag <= dec_clamp;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_csc_para_ctrl.sv
`default_nettype none
// tb_csc_para_ctrl: directed self-checking bench for csc_para_ctrl.
module tb_csc_para_ctrl;

    localparam int PARA_DW = 12;
    localparam int NUM_CH  = 3;
    localparam int ROUND_W = 18;
    localparam int CW      = NUM_CH*3*PARA_DW;
    localparam int OW      = NUM_CH*(PARA_DW+8);

    logic                 clk_in = 1'b0;
    logic                 rst_in;
    logic                 cfg_vld;
    logic                 cfg_rdy;
    logic [3:0]           cfg_addr;
    logic [PARA_DW+7:0]   cfg_data;
    logic                 cfg_commit;
    logic                 frame_start;
    logic [CW-1:0]        coef_flat;
    logic [OW-1:0]        offs_flat;
    logic [4:0]           shift_eff;
    logic [ROUND_W-1:0]   round_val;
    logic                 offset_en;
    logic                 clamp_flag;
    logic                 para_upd;
    logic                 cfg_err;
    logic                 pending;

    int n_chk  = 0;
    int n_pass = 0;

    logic [CW-1:0] exp_coef;
    logic [OW-1:0] exp_offs;

    csc_para_ctrl #(
        .PARA_DW       (PARA_DW),
        .NUM_CH        (NUM_CH),
        .SHIFT_MIN     (8),
        .SHIFT_MAX     (17),
        .OFF_SHIFT_MAX (14),
        .ROUND_W       (ROUND_W)
    ) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .cfg_vld     (cfg_vld),
        .cfg_rdy     (cfg_rdy),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .cfg_commit  (cfg_commit),
        .frame_start (frame_start),
        .coef_flat   (coef_flat),
        .offs_flat   (offs_flat),
        .shift_eff   (shift_eff),
        .round_val   (round_val),
        .offset_en   (offset_en),
        .clamp_flag  (clamp_flag),
        .para_upd    (para_upd),
        .cfg_err     (cfg_err),
        .pending     (pending)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [PARA_DW+7:0] d);
        cfg_vld  = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        tick();
        cfg_vld  = 1'b0;
    endtask

    // Commit, frame pulse in PENDING, then one APPLY cycle: returns in the para_upd cycle.
    task automatic do_apply();
        cfg_commit = 1'b1;
        tick();
        cfg_commit  = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
    endtask

    task automatic chk_active(input string tag, input logic [4:0] sh, input logic [ROUND_W-1:0] rv,
                              input logic oe, input logic cf);
        chk({tag, "_shift"}, 128'(shift_eff), 128'(sh));
        chk({tag, "_round"}, 128'(round_val), 128'(rv));
        chk({tag, "_offen"}, 128'(offset_en), 128'(oe));
        chk({tag, "_clamp"}, 128'(clamp_flag), 128'(cf));
        chk({tag, "_coef"},  128'(coef_flat), 128'(exp_coef));
        chk({tag, "_offs"},  128'(offs_flat), 128'(exp_offs));
    endtask

    initial begin
        rst_in = 1'b1; cfg_vld = 1'b0; cfg_addr = '0; cfg_data = '0;
        cfg_commit = 1'b0; frame_start = 1'b0;
        exp_coef = '0; exp_offs = '0;
        repeat (3) tick();
        chk("rdy_in_reset", 128'(cfg_rdy), 128'(0));
        rst_in = 1'b0;
        #1;
        chk("rst_rdy", 128'(cfg_rdy), 128'(1));
        chk("rst_pending", 128'(pending), 128'(0));
        chk("rst_upd", 128'(para_upd), 128'(0));
        chk("rst_err", 128'(cfg_err), 128'(0));
        chk_active("rst", 5'd8, 18'd128, 1'b1, 1'b0);

        // shift 15 + ch1 col2 coefficient, frame 4 cycles after commit
        wr(4'd12, 20'd15);
        wr(4'd6, 20'h3A5);
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        chk("commit_pending", 128'(pending), 128'(1));
        chk("commit_rdy", 128'(cfg_rdy), 128'(0));
        repeat (3) tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("apply_no_upd_yet", 128'(para_upd), 128'(0));
        chk("apply_round_old", 128'(round_val), 128'(128));
        tick();
        exp_coef[5*PARA_DW +: PARA_DW] = 12'h3A5;
        chk("s15_upd", 128'(para_upd), 128'(1));
        chk("s15_pending", 128'(pending), 128'(0));
        chk("s15_rdy", 128'(cfg_rdy), 128'(1));
        chk_active("s15", 5'd15, 18'd16384, 1'b0, 1'b0);
        tick();
        chk("s15_upd_once", 128'(para_upd), 128'(0));

        // clamp low and high
        wr(4'd12, 20'd3);
        do_apply();
        chk_active("s3", 5'd8, 18'd128, 1'b1, 1'b1);
        wr(4'd12, 20'd25);
        do_apply();
        chk_active("s25", 5'd17, 18'd65536, 1'b0, 1'b1);

        // legal offset write, then illegal address
        wr(4'd3, 20'hABCDE);
        chk("legal_no_err", 128'(cfg_err), 128'(0));
        wr(4'd13, 20'h12345);
        chk("illegal_err", 128'(cfg_err), 128'(1));
        tick();
        chk("illegal_err_pulse", 128'(cfg_err), 128'(0));
        do_apply();
        exp_offs[19:0] = 20'hABCDE;
        chk_active("illegal", 5'd17, 18'd65536, 1'b0, 1'b1);

        // write attempted while pending is back-pressured
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        cfg_vld = 1'b1; cfg_addr = 4'd0; cfg_data = 20'h777;
        #1;
        chk("pend_rdy", 128'(cfg_rdy), 128'(0));
        tick();
        cfg_vld = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        chk("pend_upd", 128'(para_upd), 128'(1));
        chk("pend_coef", 128'(coef_flat), 128'(exp_coef));

        // write + commit + frame in one IDLE cycle: frame ignored, write included
        cfg_vld = 1'b1; cfg_addr = 4'd0; cfg_data = 20'h055;
        cfg_commit = 1'b1; frame_start = 1'b1;
        tick();
        cfg_vld = 1'b0; cfg_commit = 1'b0; frame_start = 1'b0;
        tick();
        chk("same_cyc_upd", 128'(para_upd), 128'(0));
        chk("same_cyc_pending", 128'(pending), 128'(1));
        chk("same_cyc_coef_old", 128'(coef_flat), 128'(exp_coef));
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        exp_coef[PARA_DW-1:0] = 12'h055;
        chk("next_frame_upd", 128'(para_upd), 128'(1));
        chk("next_frame_coef", 128'(coef_flat), 128'(exp_coef));

        // frame_start without commit
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("idle_frame_upd0", 128'(para_upd), 128'(0));
        tick();
        chk("idle_frame_upd1", 128'(para_upd), 128'(0));

        // reset during PENDING discards the armed update
        wr(4'd12, 20'd10);
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        chk("rst_mid_pending_pre", 128'(pending), 128'(1));
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        #1;
        exp_coef = '0; exp_offs = '0;
        chk("rst_mid_pending", 128'(pending), 128'(0));
        chk_active("rst_mid", 5'd8, 18'd128, 1'b1, 1'b0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        chk("rst_mid_no_upd", 128'(para_upd), 128'(0));
        chk("rst_mid_shift", 128'(shift_eff), 128'(8));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/csc_para_ctrl.md
# csc_para_ctrl

Parametrised, double-buffered parameter controller for the colour-space-conversion (YUV→RGB) datapath. It accepts coefficient, offset and shift writes over a ready/valid config port into a shadow bank. On commit it arms an update, and at the next frame boundary it copies the shadow bank to the active bank atomically. From the clamped shift it derives the exact half-LSB rounding constant and the offset-enable. It sits between the register/config bus and the CSC multiply-accumulate array.

## Interface
- PARA_DW, 12: coefficient width; offsets are PARA_DW+8 wide.
- NUM_CH, 3: output channels (1..3); each channel has 3 coefficients and 1 offset.
- SHIFT_MIN, 8: lowest legal shift.
- SHIFT_MAX, 17: highest legal shift.
- OFF_SHIFT_MAX, 14: offset is enabled while shift_eff ≤ this value.
- ROUND_W, 18: rounding constant width; must be ≥ SHIFT_MAX.
- clk_in  in  1  clock.
- rst_in  in  1  reset, synchronous, active-high.
- cfg_vld  in  1  config write valid.
- cfg_rdy  out  1  config write ready.
- cfg_addr  in  4  word address: ch*4+col, where col 0..2 is a coefficient and col 3 is the offset. NUM_CH*4 is the shift word.
- cfg_data  in  PARA_DW+8  write data; coefficients use the low PARA_DW bits and shift uses bits [4:0].
- cfg_commit  in  1  arm a shadow→active update.
- frame_start  in  1  one-cycle frame-boundary pulse.
- coef_flat  out  NUM_CH*3*PARA_DW  active coefficients, channel-major.
- offs_flat  out  NUM_CH*(PARA_DW+8)  active offsets.
- shift_eff  out  5  active clamped shift.
- round_val  out  ROUND_W  active value 1<<(shift_eff-1).
- offset_en  out  1  active offset enable.
- clamp_flag  out  1  active shift was clamped.
- para_upd  out  1  one-cycle pulse when the active bank changes.
- cfg_err  out  1  one-cycle pulse on a write to an illegal address.
- pending  out  1  commit armed, waiting for a frame boundary.

## Operation
- FSM has three states, IDLE / PENDING / APPLY.
- Transitions:
  - IDLE→PENDING on cfg_commit.
  - PENDING→APPLY on frame_start.
  - APPLY→IDLE unconditionally after 1 cycle.
- Write acceptance:
  - A write is accepted when cfg_vld && cfg_rdy.
  - cfg_rdy=1 only in IDLE and not while rst_in is high.
  - In PENDING and APPLY, writes are back-pressured so the shadow bank stays stable.
- Address decode:
  - Legal addresses are ch*4+col with ch < NUM_CH, plus the shift word at NUM_CH*4.
  - Any other accepted address drops the data and pulses cfg_err the next cycle.
- Shift clamp:
  - The raw shift is stored unclamped in the shadow bank.
  - At APPLY, shift_eff = max(SHIFT_MIN, min(SHIFT_MAX, raw)).
  - clamp_flag = (raw ≠ shift_eff).
- Derived values:
  - round_val = 1<<(shift_eff-1), zero-extended to ROUND_W.
  - offset_en = (shift_eff ≤ OFF_SHIFT_MAX).
- Simultaneous events:
  - cfg_vld and cfg_commit in the same IDLE cycle: the write is accepted and included in the commit.
  - cfg_commit and frame_start in the same IDLE cycle: the commit is armed but that frame_start is ignored; the update applies at the following frame_start.
  - frame_start in IDLE has no effect.
  - cfg_commit in PENDING or APPLY is ignored; it does not re-arm.
- Reset (including reset mid-PENDING or mid-APPLY):
  - State returns to IDLE and the armed commit is discarded.
  - Shadow and active banks are loaded with defaults: coefficients 0, offsets 0, raw shift SHIFT_MIN.
  - Output reset values: coef_flat=0, offs_flat=0, shift_eff=SHIFT_MIN, round_val=1<<(SHIFT_MIN-1) (128 by default), offset_en=1 (by default), clamp_flag=0, para_upd=0, cfg_err=0, pending=0, cfg_rdy=0.

## Timing
- Write accepted in cycle N → shadow updated at the end of N. cfg_err, if raised, is high in N+1.
- cfg_commit in IDLE at cycle N → pending=1 and cfg_rdy=0 from N+1.
- frame_start sampled in PENDING at cycle M → APPLY in M+1. In M+2:
  - all active outputs hold the new values;
  - para_upd=1 for exactly one cycle;
  - pending=0 and cfg_rdy=1.
- All active outputs are registered and change only in the para_upd cycle. No glitches occur between frames.
- Minimum commit-to-apply latency is 3 cycles (commit N, frame_start N+1, new outputs N+3).

## Structure
- Package csc_para_pkg holds:
  - the state enum;
  - address-map constants COL_OFFS=3 and ADDR_SHIFT(NUM_CH);
  - reset defaults;
  - the clamp function.
- Sub-module csc_shift_decode is combinational: raw shift → shift_eff, round_val, offset_en, clamp_flag. It is instantiated once, on the shadow→active path.

## Test plan
- Reset → defaults: round_val=128, offset_en=1, shift_eff=8, cfg_rdy=1 from the first cycle after reset release.
- Write shift=15 and ch1 col2 coef=0x3A5, commit at cycle N, frame_start at N+4 → at N+6: round_val=16384, offset_en=0, coef ch1c2=0x3A5, para_upd pulses once.
- Write shift=3, commit, frame → shift_eff=8, clamp_flag=1, round_val=128. Write shift=25, commit, frame → shift_eff=17, round_val=65536, clamp_flag=1, offset_en=0.
- NUM_CH=3, write addr 13 → cfg_err pulse and no change after commit. Write while pending → cfg_rdy=0, write not accepted.
- cfg_commit together with frame_start → no update on that frame, update on the next frame_start. frame_start without commit → para_upd stays 0.
- Commit, then rst_in during PENDING → pending=0, outputs back to defaults, and a later frame_start causes no update.
